// File: rtl/opu_arbiter.sv
// opu_arbiter: shares one OPU between N_REQ requesters using round-robin
// arbitration. Each accepted command is issued to the OPU as a one-cycle
// op_start. The result, or a timeout abort, is returned to the winner.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req           per-requester request level
//   req_op_code   2-bit op code per requester, requester i at [2i+1:2i]
//   req_data      DATA_W operand per requester, requester i at slice i
//   gnt           one-hot pulse, command of requester i accepted
//   rsp_valid     one-hot pulse, response for requester i
//   rsp_data      result, qualified by rsp_valid
//   rsp_err       1 = timeout abort, qualified by rsp_valid
//   busy          high whenever not idle
//   op_start      one-cycle start pulse to the OPU
//   op_code       op code to the OPU, held from issue until idle
//   op_data       operand to the OPU, held like op_code
//   op_result     OPU result, sampled on op_done
//   op_done       OPU completion pulse
module opu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      req_op_code,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    op_start,
  output logic [1:0]              op_code,
  output logic [DATA_W-1:0]       op_data,
  input  logic [DATA_W-1:0]       op_result,
  input  logic                    op_done
);

  localparam int          IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          CNT_W = $clog2(TIMEOUT);
  localparam int unsigned NR    = N_REQ;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, idx_q;
  logic [1:0]          opc_q;
  logic [DATA_W-1:0]   opd_q, res_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [1:0]          pick_opc;
  logic [DATA_W-1:0]   pick_data;
  logic                timeout_hit;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_opc   = '0;
    pick_data  = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = (32'(last_q) + k) % NR;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
        pick_opc   = req_op_code[2*cand +: 2];
        pick_data  = req_data[DATA_W*cand +: DATA_W];
      end
    end
  end

  // WAIT lasts at most TIMEOUT cycles; the counter holds 0..TIMEOUT-1 across them.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (op_done || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: command latch, timeout counter, result, pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(N_REQ - 1);
      idx_q  <= '0;
      opc_q  <= '0;
      opd_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            idx_q <= pick_idx;
            opc_q <= pick_opc;
            opd_q <= pick_data;
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          // Completion takes precedence over a coincident timeout.
          if (op_done) begin
            res_q <= op_result;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: last_q <= idx_q;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    op_start  = 1'b0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      gnt[idx_q] = 1'b1;
      op_start   = 1'b1;
    end
    if (state_q == S_RESP) rsp_valid[idx_q] = 1'b1;
  end

  assign rsp_data = res_q;
  assign rsp_err  = err_q;
  assign op_code  = opc_q;
  assign op_data  = opd_q;

endmodule

// File: tb/tb_opu_arbiter.sv
module tb_opu_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_op_code;
  logic [W*N-1:0] req_data;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_data, op_data, op_result;
  logic           rsp_err, busy, op_start, op_done;
  logic [1:0]     op_code;

  opu_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op_code(req_op_code),
    .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .op_start(op_start), .op_code(op_code), .op_data(op_data),
    .op_result(op_result), .op_done(op_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] opc_tab [N] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [7:0] dat_tab [N] = '{8'h3C, 8'hA5, 8'h5A, 8'hF0};

  typedef struct {
    logic [N-1:0] req;
    logic         hold;      // keep req high after the grant
    int           lat;       // op_done in this WAIT cycle (0 = never)
    logic [7:0]   res;
    int           exp_idx;
    logic [7:0]   exp_data;
    logic         exp_err;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Structural invariants sampled every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      check("gnt_rsp_excl", 32'((|gnt) && (|rsp_valid)), 32'd0);
    end
  end

  // Called at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v);
    int nwait;
    req       = v.req;
    op_result = v.res;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(1 << v.exp_idx));
    check("op_start", 32'(op_start), 32'd1);
    check("op_code", 32'(op_code), 32'(opc_tab[v.exp_idx]));
    check("op_data", 32'(op_data), 32'(dat_tab[v.exp_idx]));
    if (!v.hold) req = '0;
    nwait = 0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid != '0 || nwait > 40) break;
      check("busy_wait", 32'(busy), 32'd1);
      nwait++;
      op_done = (nwait == v.lat);
    end
    op_done = 1'b0;
    check("rsp_valid", 32'(rsp_valid), 32'(1 << v.exp_idx));
    check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("wait_cycles", 32'(nwait), 32'((v.lat != 0) ? v.lat : TO));
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    check("rsp_after", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_op_start"}, 32'(op_start), 32'd0);
    check({tag, "_op_code"}, 32'(op_code), 32'd0);
    check({tag, "_op_data"}, 32'(op_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    op_done   = 1'b0;
    op_result = '0;
    for (int i = 0; i < N; i++) begin
      req_op_code[2*i +: 2] = opc_tab[i];
      req_data[W*i +: W]    = dat_tab[i];
    end

    // Fairness from reset, then single request, wrap/priority, timeout, boundary
    vt.push_back(vec_t'{4'b1111, 1'b1, 1, 8'h11, 0, 8'h11, 1'b0});
    vt.push_back(vec_t'{4'b1111, 1'b1, 1, 8'h22, 1, 8'h22, 1'b0});
    vt.push_back(vec_t'{4'b1111, 1'b1, 1, 8'h33, 2, 8'h33, 1'b0});
    vt.push_back(vec_t'{4'b1111, 1'b1, 1, 8'h44, 3, 8'h44, 1'b0});
    vt.push_back(vec_t'{4'b1111, 1'b0, 1, 8'h55, 0, 8'h55, 1'b0});
    vt.push_back(vec_t'{4'b0001, 1'b0, 2, 8'hC3, 0, 8'hC3, 1'b0});
    vt.push_back(vec_t'{4'b0100, 1'b0, 1, 8'h66, 2, 8'h66, 1'b0});
    vt.push_back(vec_t'{4'b0011, 1'b0, 1, 8'h12, 0, 8'h12, 1'b0});
    vt.push_back(vec_t'{4'b0011, 1'b0, 3, 8'h34, 1, 8'h34, 1'b0});
    vt.push_back(vec_t'{4'b0100, 1'b0, 1, 8'h56, 2, 8'h56, 1'b0});
    vt.push_back(vec_t'{4'b0100, 1'b0, 2, 8'h78, 2, 8'h78, 1'b0});
    vt.push_back(vec_t'{4'b0010, 1'b0, 0, 8'hEE, 1, 8'h00, 1'b1});
    vt.push_back(vec_t'{4'b1000, 1'b0, 1, 8'h77, 3, 8'h77, 1'b0});
    vt.push_back(vec_t'{4'b0001, 1'b0, TO, 8'h9E, 0, 8'h9E, 1'b0});

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_txn(vt[i]);

    // Stray op_done while idle
    req = '0;
    for (int i = 0; i < 3; i++) begin
      op_done = 1'b1;
      @(negedge clk);
      check("stray_busy", 32'(busy), 32'd0);
      check("stray_rsp", 32'(rsp_valid), 32'd0);
    end
    op_done = 1'b0;

    // op_done during ISSUE is ignored; the next one completes
    req       = 4'b0100;
    op_result = 8'hAB;
    @(negedge clk);
    check("iss_gnt", 32'(gnt), 32'h4);
    req     = '0;
    op_done = 1'b1;
    @(negedge clk);
    check("iss_done_ignored_busy", 32'(busy), 32'd1);
    check("iss_done_ignored_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    op_done = 1'b0;
    check("iss_rsp", 32'(rsp_valid), 32'h4);
    check("iss_data", 32'(rsp_data), 32'hAB);
    @(negedge clk);

    // Reset during WAIT: outputs clear at once, no response follows
    req = 4'b0010;
    @(negedge clk);
    check("rstw_gnt", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstw_idle", 32'(busy), 32'd0);
    end

    // Pointer restored to N-1: search starts at requester 0
    run_txn(vec_t'{4'b1001, 1'b0, 1, 8'h5D, 0, 8'h5D, 1'b0});
    run_txn(vec_t'{4'b1000, 1'b0, 1, 8'h6E, 3, 8'h6E, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
